// File: rtl/arb4_rr_stage.sv
// arb4_rr_stage: four-requester round-robin arbiter with a registered
// valid/ready output stage. Drives one-hot/zero-hot selects into an external
// 4:1 AND/OR mux and captures the selected word (mux_dout) into out_data.
//
// Optional feature macro: ARB4_LOCK_EN
//   defined   -> packet lock: after a non-last word the granted requester
//                keeps ownership until it transfers a word with req_last=1.
//   undefined -> pure word-level round-robin; req_last is ignored.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid[3:0]    requester i has a word available
//   req_last[3:0]     word from requester i ends its packet (lock build only)
//   req_ready[3:0]    combinational accept per requester (equals sel vector)
//   sel0..sel3        combinational one-hot/zero-hot mux selects
//   mux_dout          selected word from the mux
//   out_valid/out_data/out_src  registered output word and its source index
//   out_ready         downstream accepts out_data
module arb4_rr_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  output logic [3:0]       req_ready,
  output logic             sel0,
  output logic             sel1,
  output logic             sel2,
  output logic             sel3,
  input  logic [WIDTH-1:0] mux_dout,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = 2;

  logic            adv_c;
  logic            grant_c;
  logic            gnt_found;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] cand;
  logic [NREQ-1:0] sel_vec;
  logic [IDXW-1:0] ptr_q;

`ifdef ARB4_LOCK_EN
  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e     state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  // Stage can accept a new word when empty or draining this cycle.
  assign adv_c = !out_valid || out_ready;

  // Round-robin search starting at ptr; a held lock overrides the search.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = ptr_q + IDXW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
`ifdef ARB4_LOCK_EN
    if (state_q == ST_LOCKED) begin
      gnt_found = req_valid[owner_q];
      gnt_idx   = owner_q;
    end
`endif
  end

  // Selects are forced zero-hot while in reset or stalled.
  always_comb begin
    sel_vec = '0;
    if (rst_n && adv_c && gnt_found) begin
      sel_vec = NREQ'(1) << gnt_idx;
    end
  end

  assign grant_c   = |sel_vec;
  assign req_ready = sel_vec;
  assign sel0      = sel_vec[0];
  assign sel1      = sel_vec[1];
  assign sel2      = sel_vec[2];
  assign sel3      = sel_vec[3];

`ifdef ARB4_LOCK_EN
  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FREE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Lock next-state: a non-last word locks to its source, a last word frees.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (grant_c) begin
      if (req_last[gnt_idx]) begin
        state_d = ST_FREE;
      end else begin
        state_d = ST_LOCKED;
        owner_d = gnt_idx;
      end
    end
  end
`endif

  // Output register and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr_q     <= '0;
    end else if (grant_c) begin
      out_valid <= 1'b1;
      out_data  <= mux_dout;
      out_src   <= gnt_idx;
      ptr_q     <= gnt_idx + IDXW'(1);
    end else if (adv_c) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb4_rr_stage.sv
// Self-checking bench for arb4_rr_stage. Requester i always offers word
// 0xA0+i through a behavioural AND/OR mux; expected (src, data) pairs are
// queued by each scenario and popped when an output transfer is observed.
module tb_arb4_rr_stage;

  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [1:0]       src;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_last;
  logic [3:0]       req_ready;
  logic             sel0, sel1, sel2, sel3;
  logic [WIDTH-1:0] mux_dout;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;
  exp_t exp_q[$];

  arb4_rr_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .sel0      (sel0),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel3      (sel3),
    .mux_dout  (mux_dout),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural AND/OR one-hot mux.
  assign mux_dout = ({WIDTH{sel0}} & 32'h000000A0) |
                    ({WIDTH{sel1}} & 32'h000000A1) |
                    ({WIDTH{sel2}} & 32'h000000A2) |
                    ({WIDTH{sel3}} & 32'h000000A3);

  function automatic exp_t mk_exp(input logic [1:0] src);
    exp_t e;
    e.src  = src;
    e.data = 32'h000000A0 + WIDTH'(src);
    return e;
  endfunction

  // Select sanity and scoreboard pop on every output transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      checks++;
      if (!$onehot0({sel3, sel2, sel1, sel0}) || req_ready !== {sel3, sel2, sel1, sel0}) begin
        failures++;
        $display("FAIL sel_onehot0 t=%0t sel=%b req_ready=%b", $time, {sel3, sel2, sel1, sel0}, req_ready);
      end
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected t=%0t got src=%0d data=%0h expected nothing", $time, out_src, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_src !== e.src || out_data !== e.data) begin
            failures++;
            $display("FAIL sb_word t=%0t got src=%0d data=%0h expected src=%0d data=%0h",
                     $time, out_src, out_data, e.src, e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sel3, sel2, sel1, sel0} !== 4'b0000) begin
      failures++; $display("FAIL reset_sel got %b expected 0000", {sel3, sel2, sel1, sel0});
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0) begin
      failures++; $display("FAIL reset_outputs got v=%b d=%0h s=%0d expected v=0 d=0 s=0", out_valid, out_data, out_src);
    end
    exp_q.push_back(mk_exp(2'd0));
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({sel3, sel2, sel1, sel0} !== 4'b0001) begin
      failures++; $display("FAIL reset_first_grant got %b expected 0001", {sel3, sel2, sel1, sel0});
    end
    @(posedge clk); #1 req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      failures++; $display("FAIL reset_first_out got v=%b s=%0d expected v=1 s=0", out_valid, out_src);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL reset_drain got v=%b pending=%0d expected v=0 pending=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    foreach (seq[i]) exp_q.push_back(mk_exp(seq[i]));
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) req_valid = 4'b0000;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_src !== seq[k]) begin
        failures++; $display("FAIL rr_cycle%0d got v=%b s=%0d expected v=1 s=%0d", k, out_valid, out_src, seq[k]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL rr_drain got v=%b pending=%0d expected v=0 pending=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.push_back(mk_exp(2'd0));
    exp_q.push_back(mk_exp(2'd1));
    exp_q.push_back(mk_exp(2'd2));
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({sel3, sel2, sel1, sel0} !== 4'b0000 || out_valid !== 1'b1 ||
          out_data !== 32'h000000A0 || out_src !== 2'd0) begin
        failures++;
        $display("FAIL bp_stall%0d got sel=%b v=%b d=%0h s=%0d expected sel=0000 v=1 d=a0 s=0",
                 k, {sel3, sel2, sel1, sel0}, out_valid, out_data, out_src);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({sel3, sel2, sel1, sel0} !== 4'b0010) begin
      failures++; $display("FAIL bp_resume_sel got %b expected 0010", {sel3, sel2, sel1, sel0});
    end
    @(posedge clk); #1;
    @(posedge clk); #1 req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_drain got v=%b pending=%0d expected v=0 pending=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_sparse();
    do_reset();
    repeat (4) exp_q.push_back(mk_exp(2'd2));
    exp_q.push_back(mk_exp(2'd3));
    exp_q.push_back(mk_exp(2'd0));
    req_valid = 4'b0100;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 req_valid = 4'b1001;
    #1;
    checks++;
    if ({sel3, sel2, sel1, sel0} !== 4'b1000) begin
      failures++; $display("FAIL sparse_sel3 got %b expected 1000", {sel3, sel2, sel1, sel0});
    end
    @(posedge clk); #2;
    checks++;
    if ({sel3, sel2, sel1, sel0} !== 4'b0001) begin
      failures++; $display("FAIL sparse_sel0 got %b expected 0001", {sel3, sel2, sel1, sel0});
    end
    @(posedge clk); #1 req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL sparse_drain got v=%b pending=%0d expected v=0 pending=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_lock();
    logic [3:0] gap_sel;
    logic       bubble_valid;
    do_reset();
`ifdef ARB4_LOCK_EN
    exp_q.push_back(mk_exp(2'd1));
    exp_q.push_back(mk_exp(2'd1));
    exp_q.push_back(mk_exp(2'd1));
    exp_q.push_back(mk_exp(2'd2));
    gap_sel      = 4'b0000;
    bubble_valid = 1'b0;
`else
    exp_q.push_back(mk_exp(2'd1));
    exp_q.push_back(mk_exp(2'd2));
    exp_q.push_back(mk_exp(2'd2));
    exp_q.push_back(mk_exp(2'd1));
    exp_q.push_back(mk_exp(2'd2));
    gap_sel      = 4'b0100;
    bubble_valid = 1'b1;
`endif
    out_ready = 1'b1;
    req_valid = 4'b0110;
    req_last  = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1 req_valid = 4'b0100;
    #1;
    checks++;
    if ({sel3, sel2, sel1, sel0} !== gap_sel) begin
      failures++; $display("FAIL lock_gap_sel got %b expected %b", {sel3, sel2, sel1, sel0}, gap_sel);
    end
    @(posedge clk); #1 req_valid = 4'b0110; req_last = 4'b0010;
    @(negedge clk);
    checks++;
    if (out_valid !== bubble_valid) begin
      failures++; $display("FAIL lock_bubble got v=%b expected v=%b", out_valid, bubble_valid);
    end
    @(posedge clk); #1 req_valid = 4'b0100; req_last = 4'b0000;
    @(posedge clk); #1 req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL lock_drain got v=%b pending=%0d expected v=0 pending=0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.push_back(mk_exp(2'd0));
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0 ||
        {sel3, sel2, sel1, sel0} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got v=%b d=%0h s=%0d sel=%b expected v=0 d=0 s=0 sel=0000",
               out_valid, out_data, out_src, {sel3, sel2, sel1, sel0});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL async_pre_drain got pending=%0d expected 0", exp_q.size());
    end
    exp_q.push_back(mk_exp(2'd0));
    @(negedge clk); #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({sel3, sel2, sel1, sel0} !== 4'b0001) begin
      failures++; $display("FAIL async_ptr_zero got sel=%b expected 0001", {sel3, sel2, sel1, sel0});
    end
    @(posedge clk); #1 req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL async_drain got v=%b pending=%0d expected v=0 pending=0", out_valid, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    out_ready = 1'b0;
    mon_en    = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_lock();
    test_async_reset();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
